nios_system_sha_seq: RTL and testbench

Avalon-MM slave controller that sequences the SHA-256 hashing datapath for the Nios II. Software loads a 16-word (512-bit) message block into a local buffer and writes GO. The block then pulses the core start, streams the 16 words over a valid/ready interface, waits for core completion and latches the 256-bit digest into readable registers. It sits between the system interconnect and the SHA core, replacing raw PIO poking of the core's data inputs.

---
 rtl/nios_system_sha_seq.sv | 150 +++++++++++++++
 tb/tb_nios_system_sha_seq.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/nios_system_sha_seq.sv
// Avalon-MM sequencer: buffers a 16-word block, starts the SHA-256 core, streams words on valid/ready and latches the digest.
// readdata has 1-cycle latency; FEED holds sha_din/valid while ready is low. Optional irq output: define SHA_SEQ_IRQ_EN.
module nios_system_sha_seq (
    input  logic         clk,
    input  logic         reset,
    input  logic [4:0]   address,
    input  logic         write,
    input  logic [31:0]  writedata,
    output logic [31:0]  readdata,
    output logic         sha_start,
    output logic         sha_init,
    output logic [31:0]  sha_din,
    output logic         sha_din_valid,
    input  logic         sha_din_ready,
    input  logic         sha_done,
    input  logic [255:0] sha_digest
`ifdef SHA_SEQ_IRQ_EN
    ,
    output logic         irq
`endif
);

    typedef enum logic [1:0] {S_IDLE, S_START, S_FEED, S_WAIT} state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] msg_q [16];
    logic [31:0] digest_q [8];
    logic        init_q, init_d;
    logic        done_q, done_d;
    logic        err_q, err_d;
    logic [31:0] readdata_q, readdata_d;
    logic        irq_en_bit;

    logic busy, wr_msg, wr_ctrl, wr_stat, go, capture;

    assign busy    = (state_q != S_IDLE);
    assign wr_msg  = write && !address[4];
    assign wr_ctrl = write && (address == 5'h10);
    assign wr_stat = write && (address == 5'h11);
    assign go      = wr_ctrl && writedata[0];
    assign capture = (state_q == S_WAIT) && sha_done;

`ifdef SHA_SEQ_IRQ_EN
    logic irq_en_q, irq_en_d, irq_q;
    assign irq_en_d   = wr_ctrl ? writedata[2] : irq_en_q;
    assign irq_en_bit = irq_en_q;
    assign irq        = irq_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            irq_en_q <= 1'b0;
            irq_q    <= 1'b0;
        end else begin
            irq_en_q <= irq_en_d;
            irq_q    <= done_q & irq_en_q;
        end
    end
`else
    assign irq_en_bit = 1'b0;
`endif

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        init_d        = init_q;
        done_d        = done_q;
        err_d         = err_q;
        sha_start     = 1'b0;
        sha_init      = 1'b0;
        sha_din       = '0;
        sha_din_valid = 1'b0;

        if (wr_stat) begin
            if (writedata[1]) done_d = 1'b0;
            if (writedata[2]) err_d  = 1'b0;
        end
        // Software must not disturb the buffer or restart mid-block.
        if (busy && (go || wr_msg)) err_d = 1'b1;

        case (state_q)
            S_IDLE: begin
                if (go) begin
                    init_d  = writedata[1];
                    done_d  = 1'b0;
                    cnt_d   = '0;
                    state_d = S_START;
                end
            end
            S_START: begin
                sha_start = 1'b1;
                sha_init  = init_q;
                state_d   = S_FEED;
            end
            S_FEED: begin
                sha_din       = msg_q[cnt_q];
                sha_din_valid = 1'b1;
                if (sha_din_ready) begin
                    cnt_d = cnt_q + 4'd1;
                    if (cnt_q == 4'd15) state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (sha_done) begin
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        readdata_d = '0;
        if (!address[4])
            readdata_d = msg_q[address[3:0]];
        else if (address[4:3] == 2'b11)
            readdata_d = digest_q[address[2:0]];
        else if (address == 5'h10)
            readdata_d = {29'b0, irq_en_bit, init_q, 1'b0};
        else if (address == 5'h11)
            readdata_d = {29'b0, err_q, done_q, busy};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            init_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            readdata_q <= '0;
            for (int i = 0; i < 16; i++) msg_q[i] <= '0;
            for (int i = 0; i < 8; i++) digest_q[i] <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            init_q     <= init_d;
            done_q     <= done_d;
            err_q      <= err_d;
            readdata_q <= readdata_d;
            if (wr_msg && !busy) msg_q[address[3:0]] <= writedata;
            if (capture)
                for (int i = 0; i < 8; i++) digest_q[i] <= sha_digest[255-32*i -: 32];
        end
    end

    assign readdata = readdata_q;

endmodule

// File: tb/tb_nios_system_sha_seq.sv
// Bench for nios_system_sha_seq: a behavioural SHA-256 core answers the DUT, directed steps check the register map.
module tb_nios_system_sha_seq;

    logic         clk = 1'b0;
    logic         reset;
    logic [4:0]   address;
    logic         write;
    logic [31:0]  writedata;
    logic [31:0]  readdata;
    logic         sha_start, sha_init, sha_din_valid, sha_din_ready, sha_done;
    logic [31:0]  sha_din;
    logic [255:0] sha_digest;
`ifdef SHA_SEQ_IRQ_EN
    logic         irq;
`endif

    nios_system_sha_seq dut (
        .clk(clk), .reset(reset), .address(address), .write(write),
        .writedata(writedata), .readdata(readdata),
        .sha_start(sha_start), .sha_init(sha_init), .sha_din(sha_din),
        .sha_din_valid(sha_din_valid), .sha_din_ready(sha_din_ready),
        .sha_done(sha_done), .sha_digest(sha_digest)
`ifdef SHA_SEQ_IRQ_EN
        , .irq(irq)
`endif
    );

    always #5 clk = ~clk;

    localparam logic [4:0] A_CTRL = 5'h10;
    localparam logic [4:0] A_STAT = 5'h11;
    localparam logic [255:0] IV  = 256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19;
    localparam logic [255:0] ABC = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
    localparam logic [31:0] K [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        logic [63:0] t;
        t = {x, x} >> n;
        return t[31:0];
    endfunction

    function automatic logic [255:0] sha_compress(input logic [255:0] hin, input logic [31:0] m [16]);
        logic [31:0] w [64];
        logic [31:0] v [8];
        logic [31:0] hi [8];
        logic [31:0] t1, t2, s0, s1;
        logic [255:0] r;
        for (int i = 0; i < 16; i++) w[i] = m[i];
        for (int i = 16; i < 64; i++) begin
            s0 = rotr(w[i-15], 7) ^ rotr(w[i-15], 18) ^ (w[i-15] >> 3);
            s1 = rotr(w[i-2], 17) ^ rotr(w[i-2], 19) ^ (w[i-2] >> 10);
            w[i] = w[i-16] + s0 + w[i-7] + s1;
        end
        for (int i = 0; i < 8; i++) begin
            hi[i] = hin[255-32*i -: 32];
            v[i]  = hi[i];
        end
        for (int i = 0; i < 64; i++) begin
            t1 = v[7] + (rotr(v[4], 6) ^ rotr(v[4], 11) ^ rotr(v[4], 25))
                 + ((v[4] & v[5]) ^ (~v[4] & v[6])) + K[i] + w[i];
            t2 = (rotr(v[0], 2) ^ rotr(v[0], 13) ^ rotr(v[0], 22))
                 + ((v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]));
            v[7] = v[6]; v[6] = v[5]; v[5] = v[4]; v[4] = v[3] + t1;
            v[3] = v[2]; v[2] = v[1]; v[1] = v[0]; v[0] = t1 + t2;
        end
        for (int i = 0; i < 8; i++) r[255-32*i -: 32] = hi[i] + v[i];
        return r;
    endfunction

    // Core-side observations, written only by the core process.
    logic [31:0] hs_words [$];
    int          n_starts = 0;
    int          stab_viol = 0;
    logic        last_init = 1'b0;
    // Core-side controls, written only by the main sequence.
    logic        stall_mode;
    int          stray_req;

    int n_checks = 0;
    int n_errors = 0;

    initial begin : core
        logic [255:0] h_cur;
        logic [31:0]  words [16];
        logic [31:0]  prev_din;
        logic         prev_stall;
        int           nw, wait_cnt, stray_seen;
        h_cur = IV; nw = 0; wait_cnt = -1; stray_seen = 0;
        prev_stall = 1'b0; prev_din = '0;
        sha_din_ready = 1'b0; sha_done = 1'b0; sha_digest = '0;
        for (int i = 0; i < 16; i++) words[i] = '0;
        forever begin
            @(negedge clk);
            sha_done = 1'b0;
            if (prev_stall && !(sha_din_valid && sha_din == prev_din)) stab_viol++;
            if (sha_start) begin
                n_starts++;
                last_init = sha_init;
                if (sha_init) h_cur = IV;
                nw = 0;
                wait_cnt = -1;
            end
            sha_din_ready = stall_mode ? ($urandom_range(0, 1) == 1) : 1'b1;
            if (sha_din_valid && sha_din_ready) begin
                hs_words.push_back(sha_din);
                if (nw < 16) words[nw] = sha_din;
                nw++;
                if (nw == 16) wait_cnt = 20;
            end
            prev_stall = sha_din_valid && !sha_din_ready;
            prev_din   = sha_din;
            if (wait_cnt == 0) begin
                h_cur = sha_compress(h_cur, words);
                sha_digest = h_cur;
                sha_done = 1'b1;
                wait_cnt = -1;
            end else if (wait_cnt > 0) begin
                wait_cnt--;
            end
            if (stray_req != stray_seen) begin
                stray_seen = stray_req;
                sha_digest = {8{32'hDEADC0DE}};
                sha_done = 1'b1;
            end
        end
    end

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [4:0] a, input logic [31:0] d);
        @(negedge clk);
        address = a; writedata = d; write = 1'b1;
        @(negedge clk);
        write = 1'b0;
    endtask

    task automatic rd(input logic [4:0] a, output logic [31:0] d);
        @(negedge clk);
        address = a; write = 1'b0;
        @(negedge clk);
        d = readdata;
    endtask

    task automatic wait_done();
        logic [31:0] s;
        s = '0;
        for (int i = 0; i < 300; i++) begin
            rd(A_STAT, s);
            if (s[1]) break;
        end
        chk("done_within_budget", s[1], 1'b1);
    endtask

    task automatic check_digest(input string tag, input logic [255:0] exp);
        logic [31:0] d;
        logic [4:0]  a;
        for (int i = 0; i < 8; i++) begin
            a = 5'(24 + i);
            rd(a, d);
            chk($sformatf("%s_w%0d", tag, i), d, exp[255-32*i -: 32]);
        end
    endtask

    task automatic check_stream(input string tag, input int mark, input logic [31:0] m [16]);
        int bad;
        bad = 0;
        chk({tag, "_hs_count"}, hs_words.size() - mark, 16);
        if (hs_words.size() - mark >= 16) begin
            for (int i = 0; i < 16; i++) if (hs_words[mark+i] !== m[i]) bad++;
        end else begin
            bad = 16;
        end
        chk({tag, "_hs_order_bad"}, bad, 0);
    endtask

    initial begin : main
        logic [31:0]  msg_m [16];
        logic [31:0]  d;
        logic [255:0] h_model;
        int           mark, st0;
        logic         seen;

        reset = 1'b1; address = '0; write = 1'b0; writedata = '0;
        stall_mode = 1'b0; stray_req = 0;
        repeat (3) @(negedge clk);
        chk("rst_readdata", readdata, 0);
        chk("rst_outs", {sha_start, sha_init, sha_din_valid, sha_din}, 0);
        reset = 1'b0;
        rd(A_STAT, d);  chk("rst_status", d, 0);
        rd(5'h00, d);   chk("rst_msg0", d, 0);
        rd(5'h18, d);   chk("rst_digest0", d, 0);

        // Padded "abc" block, first block of a message.
        for (int i = 0; i < 16; i++) msg_m[i] = '0;
        msg_m[0] = 32'h61626380; msg_m[15] = 32'h00000018;
        for (int i = 0; i < 16; i++) wr(5'(i), msg_m[i]);
        rd(5'h0F, d); chk("msg15_rb", d, 32'h18);
        rd(5'h00, d); chk("msg0_rb", d, 32'h61626380);
        mark = hs_words.size(); st0 = n_starts;
        wr(A_CTRL, 32'h3);
        chk("go_start_pulse", {sha_start, sha_init, sha_din_valid}, 3'b110);
        @(negedge clk);
        chk("feed_first_word", {sha_start, sha_din_valid, sha_din}, {2'b01, msg_m[0]});
        wait_done();
        rd(A_STAT, d); chk("abc_status", d, 32'h2);
        check_digest("abc", ABC);
        check_stream("abc", mark, msg_m);
        chk("abc_starts", n_starts - st0, 1);
        chk("abc_init", last_init, 1'b1);
        rd(A_CTRL, d); chk("ctrl_rb_init", d, 32'h2);
        h_model = ABC;

        // Random block with ready stalls plus illegal accesses while busy.
        stall_mode = 1'b1;
        for (int i = 0; i < 16; i++) msg_m[i] = $urandom;
        for (int i = 0; i < 16; i++) wr(5'(i), msg_m[i]);
        mark = hs_words.size(); st0 = n_starts;
        wr(A_CTRL, 32'h3);
        wr(5'h03, 32'hDEADBEEF);
        wr(A_CTRL, 32'h1);
        rd(A_STAT, d); chk("busy_err_status", d, 32'h5);
        rd(5'h18, d);  chk("digest_hold", d, h_model[255:224]);
        wr(A_STAT, 32'h4);
        rd(A_STAT, d); chk("err_cleared", d, 32'h1);
        wait_done();
        rd(A_STAT, d); chk("rnd_status", d, 32'h2);
        rd(5'h03, d);  chk("msg3_protected", d, msg_m[3]);
        chk("rnd_single_start", n_starts - st0, 1);
        chk("rnd_init", last_init, 1'b1);
        chk("rnd_din_stable", stab_viol, 0);
        check_stream("rnd", mark, msg_m);
        h_model = sha_compress(IV, msg_m);
        check_digest("rnd", h_model);

        // Second block chained from the previous hash.
        stall_mode = 1'b0;
        for (int i = 0; i < 16; i++) msg_m[i] = $urandom;
        for (int i = 0; i < 16; i++) wr(5'(i), msg_m[i]);
        mark = hs_words.size(); st0 = n_starts;
        wr(A_CTRL, 32'h1);
        chk("chain_start", {sha_start, sha_init}, 2'b10);
        wait_done();
        chk("chain_init", last_init, 1'b0);
        check_stream("chain", mark, msg_m);
        h_model = sha_compress(h_model, msg_m);
        check_digest("chain", h_model);

        // Reset in the middle of FEED, then a stale completion from the core.
        mark = hs_words.size();
        wr(A_CTRL, 32'h3);
        for (int i = 0; i < 60; i++) begin
            if (hs_words.size() - mark >= 7) break;
            @(negedge clk);
        end
        chk("reach_word7", (hs_words.size() - mark >= 7), 1'b1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("rstfeed_outs", {sha_start, sha_din_valid, sha_din}, 0);
        rd(A_STAT, d); chk("rstfeed_status", d, 0);
        rd(5'h00, d);  chk("rstfeed_msg0", d, 0);
        rd(A_CTRL, d); chk("rstfeed_ctrl", d, 0);
        stray_req++;
        repeat (3) @(negedge clk);
        check_digest("stray", '0);
        rd(A_STAT, d); chk("stray_status", d, 0);

        // Unmapped addresses.
        wr(5'h12, 32'hFFFFFFFF);
        rd(5'h12, d); chk("unmapped_12", d, 0);
        rd(5'h17, d); chk("unmapped_17", d, 0);

        // Recovery after reset; IRQ_EN written alongside GO.
        for (int i = 0; i < 16; i++) msg_m[i] = '0;
        msg_m[0] = 32'h61626380; msg_m[15] = 32'h00000018;
        for (int i = 0; i < 16; i++) wr(5'(i), msg_m[i]);
        wr(A_CTRL, 32'h7);
        seen = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(posedge clk);
            if (sha_done) begin seen = 1'b1; break; end
        end
        chk("recover_done_seen", seen, 1'b1);
        @(negedge clk);
`ifdef SHA_SEQ_IRQ_EN
        chk("irq_low_at_done", irq, 1'b0);
        @(negedge clk);
        chk("irq_rise", irq, 1'b1);
        rd(A_CTRL, d); chk("ctrl_rb_irq", d, 32'h6);
`else
        rd(A_CTRL, d); chk("ctrl_rb_noirq", d, 32'h2);
`endif
        check_digest("recover", ABC);
        rd(A_STAT, d); chk("recover_status", d, 32'h2);
        wr(A_STAT, 32'h2);
`ifdef SHA_SEQ_IRQ_EN
        chk("irq_hold_at_clear", irq, 1'b1);
        @(negedge clk);
        chk("irq_fall", irq, 1'b0);
`endif
        rd(A_STAT, d); chk("done_cleared", d, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
